// File: rtl/regs_bank_responder_if.sv
// Register-manager bus between the DAQ initiator and the register-bank responder.
// Carries address/data/strobes toward the bank and readData/writeAck back.
interface regs_bank_responder_if #(
    parameter int ADDRWIDTH   = 8,
    parameter int DATA_LENGTH = 32
);
    logic [ADDRWIDTH-1:0]   address;
    logic [DATA_LENGTH-1:0] writeData;
    logic                   writeEnable;
    logic                   readEnable;
    logic                   writeAdmin;
    logic [DATA_LENGTH-1:0] readData;
    logic                   writeAck;

    modport master (
        output address, writeData, writeEnable, readEnable, writeAdmin,
        input  readData, writeAck
    );

    modport slave (
        input  address, writeData, writeEnable, readEnable, writeAdmin,
        output readData, writeAck
    );
endinterface

// File: rtl/regs_bank_responder.sv
// Register bank on the DAQ register-manager bus: RW control regs, RO status words, command strobes.
// Define REGS_BANK_ERR_STICKY_EN to add the W1C error register at 0x3F.
module regs_bank_responder #(
    parameter int                      DATA_LENGTH = 32,
    parameter int                      ADDRWIDTH   = 8,
    parameter int                      NUM_CTRL    = 8,
    parameter int                      NUM_STATUS  = 4,
    parameter logic [NUM_CTRL-1:0]     ADMIN_MASK  = 8'hC0,
    parameter logic [DATA_LENGTH-1:0]  ID_VALUE    = 32'h5D0A_0001
) (
    input  logic                              clk,
    input  logic                              reset_n,
    regs_bank_responder_if.slave              bus,
    output logic [NUM_CTRL*DATA_LENGTH-1:0]   ctrlRegs,
    input  logic [NUM_STATUS*DATA_LENGTH-1:0] statusRegs,
    output logic [DATA_LENGTH-1:0]            cmdPulse
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    localparam logic [ADDRWIDTH-1:0] A_ID  = ADDRWIDTH'(8'h00);
    localparam logic [ADDRWIDTH-1:0] A_CMD = ADDRWIDTH'(8'h01);

    state_t                                state_q, state_d;
    logic [NUM_CTRL-1:0][DATA_LENGTH-1:0]  ctrl_q, ctrl_d;
    logic [DATA_LENGTH-1:0]                readData_q, readData_d;
    logic [DATA_LENGTH-1:0]                cmdPulse_q, cmdPulse_d;
    logic [DATA_LENGTH-1:0]                rd_mux;
    logic [NUM_CTRL-1:0]                   ctrl_sel, ctrl_ok;
    logic                                  wr_go, cmd_hit;

    // A write is taken only on the first edge of a writeEnable assertion.
    assign wr_go   = (state_q == S_IDLE) && bus.writeEnable;
    assign cmd_hit = (bus.address == A_CMD);

    always_comb begin
        ctrl_sel = '0;
        ctrl_ok  = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_sel[i] = (bus.address == ADDRWIDTH'(16 + i));
            ctrl_ok[i]  = ctrl_sel[i] && (!ADMIN_MASK[i] || bus.writeAdmin);
        end
    end

`ifdef REGS_BANK_ERR_STICKY_EN
    localparam logic [ADDRWIDTH-1:0] A_ERR = ADDRWIDTH'(8'h3F);

    logic [1:0] errSticky_q, errSticky_d;
    logic [1:0] err_set, err_clr;
    logic       err_hit, wr_prot, wr_bad;

    assign err_hit = (bus.address == A_ERR);
    assign wr_prot = (|ctrl_sel) && !(|ctrl_ok);
    assign wr_bad  = !(|ctrl_sel) && !cmd_hit && !err_hit;

    // Set beats clear when both land on the same edge.
    always_comb begin
        err_set     = {wr_go && wr_bad, wr_go && wr_prot};
        err_clr     = (wr_go && err_hit) ? bus.writeData[1:0] : 2'b00;
        errSticky_d = (errSticky_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) errSticky_q <= 2'b00;
        else          errSticky_q <= errSticky_d;
    end
`endif

    always_comb begin
        rd_mux = '0;
        if (bus.address == A_ID) rd_mux = ID_VALUE;
        for (int i = 0; i < NUM_CTRL; i++)
            if (ctrl_sel[i]) rd_mux = ctrl_q[i];
        for (int j = 0; j < NUM_STATUS; j++)
            if (bus.address == ADDRWIDTH'(32 + j))
                rd_mux = statusRegs[j*DATA_LENGTH +: DATA_LENGTH];
`ifdef REGS_BANK_ERR_STICKY_EN
        if (err_hit) rd_mux = {{(DATA_LENGTH-2){1'b0}}, errSticky_q};
`endif
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        cmdPulse_d = '0;
        readData_d = bus.readEnable ? rd_mux : readData_q;
        case (state_q)
            S_IDLE: if (bus.writeEnable) state_d = S_ACK;
            S_ACK:  state_d = bus.writeEnable ? S_WAIT : S_IDLE;
            S_WAIT: if (!bus.writeEnable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wr_go) begin
            for (int i = 0; i < NUM_CTRL; i++)
                if (ctrl_ok[i]) ctrl_d[i] = bus.writeData;
            if (cmd_hit) cmdPulse_d = bus.writeData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            readData_q <= '0;
            cmdPulse_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            readData_q <= readData_d;
            cmdPulse_q <= cmdPulse_d;
        end
    end

    // Ack is decoded from state so a reset drops it immediately.
    assign bus.writeAck = (state_q == S_ACK);
    assign bus.readData = readData_q;
    assign ctrlRegs     = ctrl_q;
    assign cmdPulse     = cmdPulse_q;

endmodule
